// File: rtl/lsu_pkg.sv
// -----------------------------------------------------------------------------
// lsu_pkg: shared definitions for the RV32I load/store unit.
//   - XLEN                   : data/address width (32)
//   - TIMEOUT_CYCLES_DEFAULT : default ACCESS watchdog limit
//   - F3_*                   : RV32I funct3 encodings for loads/stores
//   - state_e                : LSU control states
// -----------------------------------------------------------------------------
package lsu_pkg;

    localparam int XLEN                   = 32;
    localparam int TIMEOUT_CYCLES_DEFAULT = 255;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RESP   = 2'd2
    } state_e;

endpackage

// File: rtl/lsu_if.sv
// -----------------------------------------------------------------------------
// lsu_if: bundle of the core request/response and data-memory port signals.
//   modport slave  : the LSU's view (consumes req_*/mem_ack/mem_rdata)
//   modport master : the environment's view (core + memory side)
// Core side  : req_valid, req_ready, req_we, req_funct3, req_addr, req_wdata,
//              stall, rsp_valid, rsp_rdata, fault
// Memory side: mem_req, mem_we, mem_addr, mem_wstrb, mem_wdata, mem_ack,
//              mem_rdata
// -----------------------------------------------------------------------------
interface lsu_if #(
    parameter int WIDTH = 32
);
    logic             req_valid;
    logic             req_ready;
    logic             req_we;
    logic [2:0]       req_funct3;
    logic [WIDTH-1:0] req_addr;
    logic [WIDTH-1:0] req_wdata;
    logic             stall;
    logic             rsp_valid;
    logic [WIDTH-1:0] rsp_rdata;
    logic             fault;
    logic             mem_req;
    logic             mem_we;
    logic [WIDTH-1:0] mem_addr;
    logic [3:0]       mem_wstrb;
    logic [WIDTH-1:0] mem_wdata;
    logic             mem_ack;
    logic [WIDTH-1:0] mem_rdata;

    modport slave (
        input  req_valid, req_we, req_funct3, req_addr, req_wdata,
               mem_ack, mem_rdata,
        output req_ready, stall, rsp_valid, rsp_rdata, fault,
               mem_req, mem_we, mem_addr, mem_wstrb, mem_wdata
    );

    modport master (
        output req_valid, req_we, req_funct3, req_addr, req_wdata,
               mem_ack, mem_rdata,
        input  req_ready, stall, rsp_valid, rsp_rdata, fault,
               mem_req, mem_we, mem_addr, mem_wstrb, mem_wdata
    );
endinterface

// File: rtl/lsu_align.sv
// -----------------------------------------------------------------------------
// lsu_align: purely combinational lane logic for the LSU.
//   we_i, funct3_i, addr_lo_i : access kind and byte offset within the word
//   wdata_i                   : raw store data (rs2)
//   rdata_i                   : raw memory read word
//   legal_o                   : funct3 legal for this direction and aligned
//   wstrb_o                   : byte strobes (zero for loads)
//   wdata_o                   : lane-replicated store data
//   rdata_o                   : shifted and sign/zero-extended load data
// -----------------------------------------------------------------------------
module lsu_align import lsu_pkg::*; (
    input  logic            we_i,
    input  logic [2:0]      funct3_i,
    input  logic [1:0]      addr_lo_i,
    input  logic [XLEN-1:0] wdata_i,
    input  logic [XLEN-1:0] rdata_i,
    output logic            legal_o,
    output logic [3:0]      wstrb_o,
    output logic [XLEN-1:0] wdata_o,
    output logic [XLEN-1:0] rdata_o
);
    logic [XLEN-1:0] shifted_s;
    logic [3:0]      strb_s;

    // Decode funct3 into legality, lanes, replicated store data and load extension
    always_comb begin
        shifted_s = rdata_i >> {addr_lo_i, 3'b000};
        legal_o   = 1'b0;
        strb_s    = 4'b0000;
        wdata_o   = {XLEN{1'b0}};
        rdata_o   = {XLEN{1'b0}};
        case (funct3_i)
            F3_B: begin
                legal_o = 1'b1;
                strb_s  = 4'b0001 << addr_lo_i;
                wdata_o = {4{wdata_i[7:0]}};
                rdata_o = {{24{shifted_s[7]}}, shifted_s[7:0]};
            end
            F3_H: begin
                legal_o = ~addr_lo_i[0];
                strb_s  = 4'b0011 << addr_lo_i;
                wdata_o = {2{wdata_i[15:0]}};
                rdata_o = {{16{shifted_s[15]}}, shifted_s[15:0]};
            end
            F3_W: begin
                legal_o = (addr_lo_i == 2'b00);
                strb_s  = 4'b1111;
                wdata_o = wdata_i;
                rdata_o = shifted_s;
            end
            // Unsigned variants exist only for loads
            F3_BU: begin
                legal_o = ~we_i;
                rdata_o = {24'h000000, shifted_s[7:0]};
            end
            F3_HU: begin
                legal_o = ~we_i & ~addr_lo_i[0];
                rdata_o = {16'h0000, shifted_s[15:0]};
            end
            default: begin
                legal_o = 1'b0;
            end
        endcase
        wstrb_o = we_i ? strb_s : 4'b0000;
    end
endmodule

// File: rtl/lsu.sv
// -----------------------------------------------------------------------------
// lsu: RV32I load/store unit. Accepts one request in IDLE, performs a single
// aligned word access with byte strobes, returns an extended load result with
// a one-cycle rsp_valid pulse, and stalls the core meanwhile.
//   clk_i, reset_i : clock and synchronous active-high reset
//   bus            : lsu_if.slave (core request/response + data-memory port)
// Optional feature: define LSU_TIMEOUT_EN to enable the ACCESS watchdog
// (TIMEOUT_CYCLES); without it ACCESS waits for mem_ack indefinitely.
// -----------------------------------------------------------------------------
module lsu import lsu_pkg::*; #(
    parameter int WIDTH = XLEN
`ifdef LSU_TIMEOUT_EN
    ,
    parameter int TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEFAULT
`endif
) (
    input logic  clk_i,
    input logic  reset_i,
    lsu_if.slave bus
);
`ifdef LSU_TIMEOUT_EN
    localparam int TMR_W = ($clog2(TIMEOUT_CYCLES + 1) > 8) ? $clog2(TIMEOUT_CYCLES + 1) : 8;
    logic [TMR_W-1:0] timer_q, timer_d;
`endif

    state_e           state_q, state_d;
    logic             we_q, we_d;
    logic [2:0]       funct3_q, funct3_d;
    logic [1:0]       addr_lo_q, addr_lo_d;
    logic             mem_req_q, mem_req_d;
    logic             mem_we_q, mem_we_d;
    logic [WIDTH-1:0] mem_addr_q, mem_addr_d;
    logic [3:0]       mem_wstrb_q, mem_wstrb_d;
    logic [WIDTH-1:0] mem_wdata_q, mem_wdata_d;
    logic             rsp_valid_q, rsp_valid_d;
    logic             fault_q, fault_d;
    logic [WIDTH-1:0] rsp_rdata_q, rsp_rdata_d;

    logic             al_we_s, al_legal_s;
    logic [2:0]       al_funct3_s;
    logic [1:0]       al_addr_lo_s;
    logic [3:0]       al_wstrb_s;
    logic [WIDTH-1:0] al_wdata_s, al_rdata_s;

    // In IDLE the align block checks the incoming request; afterwards it
    // works on the captured request so the load extract uses the right offset.
    assign al_we_s      = (state_q == IDLE) ? bus.req_we         : we_q;
    assign al_funct3_s  = (state_q == IDLE) ? bus.req_funct3     : funct3_q;
    assign al_addr_lo_s = (state_q == IDLE) ? bus.req_addr[1:0]  : addr_lo_q;

    lsu_align u_align (
        .we_i      (al_we_s),
        .funct3_i  (al_funct3_s),
        .addr_lo_i (al_addr_lo_s),
        .wdata_i   (bus.req_wdata),
        .rdata_i   (bus.mem_rdata),
        .legal_o   (al_legal_s),
        .wstrb_o   (al_wstrb_s),
        .wdata_o   (al_wdata_s),
        .rdata_o   (al_rdata_s)
    );

    assign bus.req_ready = (state_q == IDLE);
    assign bus.stall     = (bus.req_valid & (state_q == IDLE)) | (state_q == ACCESS);
    assign bus.mem_req   = mem_req_q;
    assign bus.mem_we    = mem_we_q;
    assign bus.mem_addr  = mem_addr_q;
    assign bus.mem_wstrb = mem_wstrb_q;
    assign bus.mem_wdata = mem_wdata_q;
    assign bus.rsp_valid = rsp_valid_q;
    assign bus.fault     = fault_q;
    assign bus.rsp_rdata = rsp_rdata_q;

    // Next-state and next-output logic for the IDLE/ACCESS/RESP controller
    always_comb begin
        state_d     = state_q;
        we_d        = we_q;
        funct3_d    = funct3_q;
        addr_lo_d   = addr_lo_q;
        mem_req_d   = mem_req_q;
        mem_we_d    = mem_we_q;
        mem_addr_d  = mem_addr_q;
        mem_wstrb_d = mem_wstrb_q;
        mem_wdata_d = mem_wdata_q;
        rsp_valid_d = 1'b0;
        fault_d     = 1'b0;
        rsp_rdata_d = rsp_rdata_q;
`ifdef LSU_TIMEOUT_EN
        timer_d     = timer_q;
`endif
        case (state_q)
            IDLE: begin
                if (bus.req_valid) begin
                    we_d        = bus.req_we;
                    funct3_d    = bus.req_funct3;
                    addr_lo_d   = bus.req_addr[1:0];
                    mem_addr_d  = {bus.req_addr[WIDTH-1:2], 2'b00};
                    mem_wdata_d = al_wdata_s;
                    if (al_legal_s) begin
                        state_d     = ACCESS;
                        mem_req_d   = 1'b1;
                        mem_we_d    = bus.req_we;
                        mem_wstrb_d = al_wstrb_s;
`ifdef LSU_TIMEOUT_EN
                        timer_d     = {TMR_W{1'b0}};
`endif
                    end else begin
                        // Faulting request never reaches memory
                        state_d     = RESP;
                        mem_we_d    = 1'b0;
                        mem_wstrb_d = 4'b0000;
                        rsp_valid_d = 1'b1;
                        fault_d     = 1'b1;
                        rsp_rdata_d = {WIDTH{1'b0}};
                    end
                end else begin
                    state_d = IDLE;
                end
            end
            ACCESS: begin
                if (bus.mem_ack) begin
                    state_d     = RESP;
                    mem_req_d   = 1'b0;
                    rsp_valid_d = 1'b1;
                    rsp_rdata_d = we_q ? {WIDTH{1'b0}} : al_rdata_s;
                end
`ifdef LSU_TIMEOUT_EN
                // The increment that would reach TIMEOUT_CYCLES abandons the access
                else if (timer_q == TMR_W'(TIMEOUT_CYCLES - 1)) begin
                    state_d     = RESP;
                    mem_req_d   = 1'b0;
                    rsp_valid_d = 1'b1;
                    fault_d     = 1'b1;
                    rsp_rdata_d = {WIDTH{1'b0}};
                end else begin
                    timer_d = timer_q + TMR_W'(1);
                end
`else
                else begin
                    state_d = ACCESS;
                end
`endif
            end
            RESP: begin
                state_d = IDLE;
            end
            default: begin
                state_d   = IDLE;
                mem_req_d = 1'b0;
            end
        endcase
    end

    // State and output registers with synchronous reset
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q     <= IDLE;
            we_q        <= 1'b0;
            funct3_q    <= 3'b000;
            addr_lo_q   <= 2'b00;
            mem_req_q   <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= {WIDTH{1'b0}};
            mem_wstrb_q <= 4'b0000;
            mem_wdata_q <= {WIDTH{1'b0}};
            rsp_valid_q <= 1'b0;
            fault_q     <= 1'b0;
            rsp_rdata_q <= {WIDTH{1'b0}};
`ifdef LSU_TIMEOUT_EN
            timer_q     <= {TMR_W{1'b0}};
`endif
        end else begin
            state_q     <= state_d;
            we_q        <= we_d;
            funct3_q    <= funct3_d;
            addr_lo_q   <= addr_lo_d;
            mem_req_q   <= mem_req_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_wstrb_q <= mem_wstrb_d;
            mem_wdata_q <= mem_wdata_d;
            rsp_valid_q <= rsp_valid_d;
            fault_q     <= fault_d;
            rsp_rdata_q <= rsp_rdata_d;
`ifdef LSU_TIMEOUT_EN
            timer_q     <= timer_d;
`endif
        end
    end
endmodule

// File: tb/tb_lsu.sv
// -----------------------------------------------------------------------------
// tb_lsu: directed self-checking bench for lsu. Each scenario task drives a
// request, plays the memory side, and compares against hand-computed values.
// -----------------------------------------------------------------------------
module tb_lsu;
    import lsu_pkg::*;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    lsu_if bus ();

`ifdef LSU_TIMEOUT_EN
    lsu #(.WIDTH(32), .TIMEOUT_CYCLES(8)) dut (.clk_i(clk), .reset_i(reset), .bus(bus));
`else
    lsu #(.WIDTH(32)) dut (.clk_i(clk), .reset_i(reset), .bus(bus));
`endif

    int n_cmp = 0;
    int n_bad = 0;

    // Results of the most recent transaction driven by run_req
    int          lat;
    logic [31:0] r_rdata, c_addr, c_wdata;
    logic        r_fault, saw_req, c_we, stall_ok, rsp_stall, post_valid, post_ready;
    logic [3:0]  c_wstrb;

    // Drives one request and plays memory: ack after ack_wait idle ACCESS
    // cycles (negative = never). Called and returns at #1 after a rising edge.
    task automatic run_req(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                           input logic [31:0] wdata, input int ack_wait, input logic [31:0] rdata);
        int acc = 0;
        lat = -1; r_rdata = 32'h0; r_fault = 1'b0; saw_req = 1'b0; c_addr = 32'h0;
        c_wdata = 32'h0; c_wstrb = 4'h0; c_we = 1'b0; stall_ok = 1'b1; rsp_stall = 1'b1;
        bus.req_valid = 1'b1; bus.req_we = we; bus.req_funct3 = f3;
        bus.req_addr = addr; bus.req_wdata = wdata;
        for (int cyc = 0; cyc < 60; cyc++) begin
            #1;
            if (bus.mem_req === 1'b1 && cyc == 0) saw_req = 1'b1;
            if (bus.rsp_valid === 1'b1) begin
                if (bus.mem_req === 1'b1) saw_req = 1'b1;
                lat = cyc; r_rdata = bus.rsp_rdata; r_fault = bus.fault; rsp_stall = bus.stall;
                break;
            end
            if (bus.stall !== 1'b1) stall_ok = 1'b0;
            if (bus.mem_req === 1'b1) begin
                if (!saw_req) begin
                    c_addr = bus.mem_addr; c_wdata = bus.mem_wdata;
                    c_wstrb = bus.mem_wstrb; c_we = bus.mem_we;
                end
                saw_req = 1'b1;
                acc++;
                if (ack_wait >= 0 && acc == ack_wait + 1) begin
                    bus.mem_ack = 1'b1; bus.mem_rdata = rdata;
                end
            end
            @(posedge clk); #1;
            bus.mem_ack = 1'b0; bus.mem_rdata = 32'h0;
        end
        // req_valid stays high across the RESP edge: the LSU must not accept it
        @(posedge clk); #1;
        post_valid = bus.rsp_valid;
        post_ready = bus.req_ready & ~bus.mem_req;
        bus.req_valid = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1; bus.req_valid = 1'b0; bus.req_we = 1'b0; bus.req_funct3 = 3'b000;
        bus.req_addr = 32'h0; bus.req_wdata = 32'h0; bus.mem_ack = 1'b0; bus.mem_rdata = 32'h0;
        repeat (3) @(posedge clk);
        #1; reset = 1'b0; #1;
        n_cmp++; if ({bus.req_ready, bus.stall, bus.rsp_valid, bus.fault, bus.mem_req, bus.mem_we} !== 6'b100000) begin
            n_bad++; $display("FAIL reset_ctrl: got %b want 100000", {bus.req_ready, bus.stall, bus.rsp_valid, bus.fault, bus.mem_req, bus.mem_we}); end
        n_cmp++; if ({bus.mem_addr, bus.mem_wdata, bus.rsp_rdata, bus.mem_wstrb} !== 100'h0) begin
            n_bad++; $display("FAIL reset_data: got %h want 0", {bus.mem_addr, bus.mem_wdata, bus.rsp_rdata, bus.mem_wstrb}); end
    endtask

    task automatic test_load();
        run_req(1'b0, F3_W, 32'h0000_0100, 32'h0, 0, 32'hDEAD_BEEF);
        n_cmp++; if (lat !== 2) begin n_bad++; $display("FAIL lw_latency: got %0d want 2", lat); end
        n_cmp++; if (r_rdata !== 32'hDEAD_BEEF) begin n_bad++; $display("FAIL lw_rdata: got %h want deadbeef", r_rdata); end
        n_cmp++; if ({r_fault, c_we, c_wstrb} !== 6'b000000) begin n_bad++; $display("FAIL lw_fault_we_wstrb: got %b want 000000", {r_fault, c_we, c_wstrb}); end
        n_cmp++; if (c_addr !== 32'h0000_0100) begin n_bad++; $display("FAIL lw_addr: got %h want 00000100", c_addr); end
        n_cmp++; if ({rsp_stall, post_valid, post_ready} !== 3'b001) begin n_bad++; $display("FAIL lw_resp_shape: got %b want 001", {rsp_stall, post_valid, post_ready}); end
        run_req(1'b0, F3_B, 32'h0000_0103, 32'h0, 0, 32'h80FF_FF00);
        n_cmp++; if (r_rdata !== 32'hFFFF_FF80) begin n_bad++; $display("FAIL lb_rdata: got %h want ffffff80", r_rdata); end
        run_req(1'b0, F3_BU, 32'h0000_0103, 32'h0, 0, 32'h80FF_FF00);
        n_cmp++; if (r_rdata !== 32'h0000_0080) begin n_bad++; $display("FAIL lbu_rdata: got %h want 00000080", r_rdata); end
        n_cmp++; if (c_addr !== 32'h0000_0100) begin n_bad++; $display("FAIL lbu_addr: got %h want 00000100", c_addr); end
        run_req(1'b0, F3_H, 32'h0000_0102, 32'h0, 0, 32'h80FF_FF00);
        n_cmp++; if (r_rdata !== 32'hFFFF_80FF) begin n_bad++; $display("FAIL lh_rdata: got %h want ffff80ff", r_rdata); end
        run_req(1'b0, F3_HU, 32'h0000_0102, 32'h0, 0, 32'h80FF_FF00);
        n_cmp++; if (r_rdata !== 32'h0000_80FF) begin n_bad++; $display("FAIL lhu_rdata: got %h want 000080ff", r_rdata); end
        run_req(1'b0, F3_B, 32'h0000_0101, 32'h0, 0, 32'h1234_7F56);
        n_cmp++; if (r_rdata !== 32'h0000_007F) begin n_bad++; $display("FAIL lb_pos_rdata: got %h want 0000007f", r_rdata); end
    endtask

    task automatic test_store();
        run_req(1'b1, F3_H, 32'h0000_0202, 32'h1234_ABCD, 0, 32'hFFFF_FFFF);
        n_cmp++; if (c_addr !== 32'h0000_0200) begin n_bad++; $display("FAIL sh_addr: got %h want 00000200", c_addr); end
        n_cmp++; if ({c_we, c_wstrb} !== 5'b11100) begin n_bad++; $display("FAIL sh_we_wstrb: got %b want 11100", {c_we, c_wstrb}); end
        n_cmp++; if (c_wdata !== 32'hABCD_ABCD) begin n_bad++; $display("FAIL sh_wdata: got %h want abcdabcd", c_wdata); end
        n_cmp++; if ({r_rdata, r_fault} !== 33'h0) begin n_bad++; $display("FAIL sh_rsp: got %h want 0", {r_rdata, r_fault}); end
        run_req(1'b1, F3_B, 32'h0000_0301, 32'h0000_00A5, 0, 32'h0);
        n_cmp++; if ({c_wstrb, c_wdata} !== {4'b0010, 32'hA5A5_A5A5}) begin n_bad++; $display("FAIL sb_lanes: got %h want 2a5a5a5a5", {c_wstrb, c_wdata}); end
        run_req(1'b1, F3_W, 32'h0000_0400, 32'hCAFE_F00D, 0, 32'h0);
        n_cmp++; if ({c_wstrb, c_wdata} !== {4'b1111, 32'hCAFE_F00D}) begin n_bad++; $display("FAIL sw_lanes: got %h want fcafef00d", {c_wstrb, c_wdata}); end
    endtask

    task automatic test_fault();
        run_req(1'b0, F3_W, 32'h0000_0101, 32'h0, 0, 32'h5555_5555);
        n_cmp++; if ({lat[3:0], r_fault, saw_req} !== 6'b0001_10) begin n_bad++; $display("FAIL lw_misalign: got lat=%0d fault=%b req=%b want lat=1 fault=1 req=0", lat, r_fault, saw_req); end
        n_cmp++; if (r_rdata !== 32'h0) begin n_bad++; $display("FAIL lw_misalign_rdata: got %h want 0", r_rdata); end
        run_req(1'b1, F3_H, 32'h0000_0203, 32'h1234_5678, 0, 32'h0);
        n_cmp++; if ({lat[3:0], r_fault, saw_req} !== 6'b0001_10) begin n_bad++; $display("FAIL sh_misalign: got lat=%0d fault=%b req=%b want lat=1 fault=1 req=0", lat, r_fault, saw_req); end
        n_cmp++; if ({post_valid, post_ready} !== 2'b01) begin n_bad++; $display("FAIL sh_misalign_pulse: got %b want 01", {post_valid, post_ready}); end
        run_req(1'b1, F3_BU, 32'h0000_0000, 32'h0, 0, 32'h0);
        n_cmp++; if ({r_fault, saw_req} !== 2'b10) begin n_bad++; $display("FAIL store_f3_100: got %b want 10", {r_fault, saw_req}); end
        run_req(1'b0, 3'b011, 32'h0000_0000, 32'h0, 0, 32'h0);
        n_cmp++; if ({r_fault, saw_req} !== 2'b10) begin n_bad++; $display("FAIL load_f3_011: got %b want 10", {r_fault, saw_req}); end
    endtask

    task automatic test_wait();
        run_req(1'b0, F3_W, 32'h0000_0500, 32'h0, 4, 32'h1357_2468);
        n_cmp++; if (lat !== 6) begin n_bad++; $display("FAIL wait_latency: got %0d want 6", lat); end
        n_cmp++; if ({stall_ok, rsp_stall, post_valid} !== 3'b100) begin n_bad++; $display("FAIL wait_stall_pulse: got %b want 100", {stall_ok, rsp_stall, post_valid}); end
        n_cmp++; if (r_rdata !== 32'h1357_2468) begin n_bad++; $display("FAIL wait_rdata: got %h want 13572468", r_rdata); end
    endtask

    task automatic test_back_to_back();
        run_req(1'b0, F3_W, 32'h0000_0010, 32'h0, 0, 32'h1111_1111);
        run_req(1'b0, F3_W, 32'h0000_0014, 32'h0, 1, 32'h2222_2222);
        n_cmp++; if ({lat[3:0], r_rdata} !== {4'd3, 32'h2222_2222}) begin n_bad++; $display("FAIL b2b_second: got lat=%0d rdata=%h want lat=3 rdata=22222222", lat, r_rdata); end
        n_cmp++; if (c_addr !== 32'h0000_0014) begin n_bad++; $display("FAIL b2b_addr: got %h want 00000014", c_addr); end
    endtask

    task automatic test_reset_in_access();
        bus.req_valid = 1'b1; bus.req_we = 1'b0; bus.req_funct3 = F3_W; bus.req_addr = 32'h0000_0600;
        @(posedge clk); #1;
        n_cmp++; if (bus.mem_req !== 1'b1) begin n_bad++; $display("FAIL rst_acc_req: got %b want 1", bus.mem_req); end
        reset = 1'b1; bus.req_valid = 1'b0;
        @(posedge clk); #1;
        reset = 1'b0;
        n_cmp++; if ({bus.mem_req, bus.req_ready, bus.rsp_valid, bus.stall} !== 4'b0100) begin n_bad++; $display("FAIL rst_acc_idle: got %b want 0100", {bus.mem_req, bus.req_ready, bus.rsp_valid, bus.stall}); end
        // A stray ack while idle must not produce a response
        bus.mem_ack = 1'b1; bus.mem_rdata = 32'hFFFF_FFFF;
        @(posedge clk); #1;
        bus.mem_ack = 1'b0; bus.mem_rdata = 32'h0;
        n_cmp++; if ({bus.rsp_valid, bus.req_ready} !== 2'b01) begin n_bad++; $display("FAIL idle_ack_ignored: got %b want 01", {bus.rsp_valid, bus.req_ready}); end
    endtask

`ifdef LSU_TIMEOUT_EN
    task automatic test_timeout();
        run_req(1'b0, F3_W, 32'h0000_0700, 32'h0, -1, 32'h0);
        n_cmp++; if ({lat[4:0], r_fault, r_rdata} !== {5'd9, 1'b1, 32'h0}) begin n_bad++; $display("FAIL timeout_rsp: got lat=%0d fault=%b rdata=%h want lat=9 fault=1 rdata=0", lat, r_fault, r_rdata); end
        bus.mem_ack = 1'b1; bus.mem_rdata = 32'hAAAA_AAAA;
        for (int i = 0; i < 2; i++) begin
            @(posedge clk); #1;
            n_cmp++; if (bus.rsp_valid !== 1'b0) begin n_bad++; $display("FAIL late_ack: got %b want 0", bus.rsp_valid); end
        end
        bus.mem_ack = 1'b0; bus.mem_rdata = 32'h0;
    endtask
`endif

    initial begin
        test_reset();
        test_load();
        test_store();
        test_fault();
        test_wait();
        test_back_to_back();
        test_reset_in_access();
`ifdef LSU_TIMEOUT_EN
        test_timeout();
`endif
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got no completion want finish before time limit");
        $fatal(1, "time limit reached");
    end
endmodule

// File: doc/lsu.md
# lsu

Load/store unit sitting directly downstream of the ALU in the RV32I core: it consumes the ALU result as the effective address, plus rs2 and funct3 from decode. It issues a single aligned word access with byte strobes over a request/acknowledge data-memory port. It returns a sign- or zero-extended load result, and stalls the core until the access completes.

## Interface
- WIDTH, 32, data and address width (fixed at 32 for RV32I)
- TIMEOUT_CYCLES, 255, watchdog limit in cycles (used only when LSU_TIMEOUT_EN is defined)

- clk  in  1  single clock, rising edge
- reset  in  1  synchronous, active-high
- req_valid  in  1  core requests a load/store this cycle (held by core while stalled)
- req_ready  out  1  LSU idle and able to accept
- req_we  in  1  1 = store, 0 = load
- req_funct3  in  3  RV32I funct3 (LB/LH/LW/LBU/LHU, SB/SH/SW)
- req_addr  in  WIDTH  effective address (ALU output)
- req_wdata  in  WIDTH  store data (rs2)
- stall  out  1  freeze PC/pipeline
- rsp_valid  out  1  one-cycle completion pulse
- rsp_rdata  out  WIDTH  extended load data (0 for stores and faults)
- fault  out  1  coincident with rsp_valid: misaligned, illegal funct3 or timeout
- mem_req  out  1  memory request, held until ack
- mem_we  out  1  memory write enable
- mem_addr  out  WIDTH  word address, {req_addr[31:2], 2'b00}
- mem_wstrb  out  4  byte lane strobes
- mem_wdata  out  WIDTH  lane-replicated store data
- mem_ack  in  1  memory completion, sampled only while mem_req is high
- mem_rdata  in  WIDTH  read word, valid with mem_ack

## Operation
- FSM states: IDLE, ACCESS, RESP. Reset state is IDLE.
- IDLE: req_ready=1. On req_valid, the LSU registers we/funct3/addr/wdata.
  - Legal and aligned request: go to ACCESS.
  - Otherwise: go to RESP with fault set.
- ACCESS: mem_req=1; all mem_* outputs are stable. On mem_ack, capture mem_rdata and go to RESP.
- RESP: rsp_valid=1 for exactly one cycle, then go to IDLE. The LSU never accepts in RESP, even though req_valid is still high.
- Alignment rules:
  - Halfword faults if addr[0]=1.
  - Word faults if addr[1:0]≠0.
  - Legal load funct3: 000, 001, 010, 100, 101. Legal store funct3: 000, 001, 010. Any other value faults.
  - A faulting request never asserts mem_req, so a misaligned store writes nothing.
- Store lanes:
  - SB: wstrb=4'b0001<<addr[1:0]; wdata = byte replicated ×4.
  - SH: wstrb=4'b0011<<addr[1:0]; wdata = halfword replicated ×2.
  - SW: wstrb=4'b1111.
  - Loads drive wstrb=0.
- Load extract: shift mem_rdata right by 8·addr[1:0].
  - LB and LH sign-extend bit 7 and bit 15 respectively.
  - LBU and LHU zero-extend.
  - LW passes through.
- stall = (req_valid & IDLE) | ACCESS. In RESP, stall=0, so the core writes back and advances in that cycle.
- Reset outputs:
  - req_ready=1.
  - stall, rsp_valid, fault, mem_req, mem_we = 0.
  - mem_addr, mem_wdata, rsp_rdata = 0; mem_wstrb=0.
- Reset during ACCESS: on the next edge the LSU is in IDLE and mem_req drops. The memory must tolerate an abandoned request.
- mem_ack outside ACCESS is ignored.

## Timing
- Cycle 0: accept, stall=1.
- Cycle 1: mem_req=1. The earliest ack is in the same cycle (combinational memory).
- Cycle after ack: rsp_valid=1, stall=0.
- Zero-wait access: 3 cycles from accept to rsp_valid inclusive. Each wait state adds one cycle.
- Fault path: accept at cycle 0, rsp_valid at cycle 1.
- Back-to-back requests: a new request is accepted no earlier than the cycle after RESP.

## Configuration
- LSU_TIMEOUT_EN defined: an 8-bit-or-wider counter clears on entry to ACCESS and increments each cycle without ack. When it reaches TIMEOUT_CYCLES:
  - the next cycle is RESP with fault=1 and rsp_rdata=0;
  - mem_req drops;
  - a late ack is ignored.
- LSU_TIMEOUT_EN undefined: no counter; ACCESS waits indefinitely.

## Structure
- Shared package lsu_pkg holds:
  - funct3 constants (F3_B, F3_H, F3_W, F3_BU, F3_HU);
  - the state enumeration (IDLE, ACCESS, RESP);
  - the default for TIMEOUT_CYCLES.
- One combinational sub-module, lsu_align: store lane replication, strobes, alignment check and load extract/extension. The FSM and registers stay in lsu.

## Test plan
- LW at addr 0x100; memory acks in ACCESS cycle 1 with 0xDEADBEEF. Required: mem_addr=0x100, wstrb=0, rsp_valid in cycle 2, rsp_rdata=0xDEADBEEF, fault=0.
- LB at 0x103 and LBU at 0x103, with rdata=0x80FF_FF00. Required: LB → 0xFFFFFF80, LBU → 0x00000080.
- SH at 0x202 with wdata=0x1234ABCD. Required: mem_addr=0x200, mem_wstrb=4'b1100, mem_wdata=0xABCDABCD, mem_we=1.
- LW at 0x101 and SH at 0x203. Required: mem_req never asserted; rsp_valid and fault in cycle 1; rsp_rdata=0.
- Ack delayed 4 cycles. Required: stall high through the wait, rsp_valid exactly one cycle after ack. A reset asserted during ACCESS must yield IDLE, mem_req=0 and req_ready=1 on the next edge.
- With LSU_TIMEOUT_EN and TIMEOUT_CYCLES=8, no ack arrives. Required: fault with rsp_valid after 8 cycles in ACCESS; a later ack is ignored.
